// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
// Optional SCAN support elsewhere is guarded by DECODER_SCAN_EN.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } dec_state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Sized for the widest supported decoder (N = 6); callers truncate to OUTS.
   function automatic logic [63:0] onehot(input logic [5:0] idx, input logic pol);
      logic [63:0] v;
      v = 64'd1 << idx;
      return pol ? v : ~v;
   endfunction

endpackage

// File: rtl/dec_prescaler.sv
// Step-tick generator for SCAN mode: ticks every PRESCALE cycles while not cleared.
module dec_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/decoder_nx_scan.sv
// Registered one-hot decoder with DIRECT (handshaked select) and SCAN (auto-step) modes.
// SCAN, its prescaler and the wrap pulse exist only when DECODER_SCAN_EN is defined.
module decoder_nx_scan
   import decoder_pkg::*;
#(
   parameter int N        = 3,
   parameter int PRESCALE = 4,
   parameter bit OUT_POL  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            mode,
   input  logic            sel_valid,
   output logic            sel_ready,
   input  logic [N-1:0]    sel,
   output logic [2**N-1:0] dout,
   output logic [N-1:0]    idx,
   output logic            wrap,
   output dec_state_t      state_dbg
);

   localparam int OUTS = 2**N;
   localparam logic [OUTS-1:0] NONE = OUT_POL ? '0 : '1;

   // Handshake: sel is consumed on any rising edge where sel_valid && sel_ready;
   // sel_ready depends only on the registered state, never on sel_valid.

   dec_state_t       st_q, st_d;
   logic [OUTS-1:0]  dout_q, dout_d;
   logic [N-1:0]     idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             tick;

`ifdef DECODER_SCAN_EN
   logic scan_clear;

   always_comb begin
      st_d = IDLE;
      if (en) begin
         st_d = (mode == MODE_DIRECT) ? DIRECT : SCAN;
      end
   end

   // The prescaler only runs while SCAN persists across an edge, so entry and exit restart it.
   assign scan_clear = !((st_q == SCAN) && (st_d == SCAN));

   dec_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (scan_clear),
      .tick_o  (tick)
   );
`else
   logic unused_mode;

   assign unused_mode = (mode == MODE_SCAN);
   assign tick        = 1'b0;

   always_comb begin
      st_d = en ? DIRECT : IDLE;
   end
`endif

   always_comb begin
      dout_d = dout_q;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      case (st_q)
         DIRECT: begin
            if (sel_valid) begin
               idx_d  = sel;
               dout_d = OUTS'(onehot(6'(sel), OUT_POL));
            end
         end
         SCAN: begin
            if (tick) begin
               idx_d  = idx_q + N'(1);
               dout_d = OUTS'(onehot(6'(idx_q + N'(1)), OUT_POL));
               wrap_d = &idx_q;
            end
         end
         default: ;
      endcase
      if ((st_d == SCAN) && (st_q != SCAN)) begin
         idx_d  = '0;
         dout_d = OUTS'(onehot(6'd0, OUT_POL));
      end
      // Dropping enable blanks the output on the same edge; idx keeps its value.
      if (st_d == IDLE) begin
         dout_d = NONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         dout_q <= NONE;
         idx_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         dout_q <= dout_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
      end
   end

   assign sel_ready = (st_q == DIRECT);
`ifdef DECODER_SCAN_EN
   assign wrap      = wrap_q;
`else
   assign wrap      = 1'b0;
`endif
   assign dout      = dout_q;
   assign idx       = idx_q;
   assign state_dbg = st_q;

endmodule

// File: tb/tb_decoder_nx_scan.sv
// Randomised scoreboard bench for decoder_nx_scan (N=3, PRESCALE=4, OUT_POL=1).
module tb_decoder_nx_scan;
   import decoder_pkg::*;

   localparam int N        = 3;
   localparam int PRESCALE = 4;
   localparam bit OUT_POL  = 1'b1;
   localparam int OUTS     = 2**N;
   localparam int EW       = 2 + 1 + 1 + N + OUTS;

`ifdef DECODER_SCAN_EN
   localparam bit SCAN_ON = 1'b1;
`else
   localparam bit SCAN_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            en = 1'b0;
   logic            mode = 1'b0;
   logic            sel_valid = 1'b0;
   logic [N-1:0]    sel = '0;
   logic            sel_ready;
   logic [OUTS-1:0] dout;
   logic [N-1:0]    idx;
   logic            wrap;
   dec_state_t      state_dbg;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];

   // Reference model: plain mode/index/counter bookkeeping.
   int m_mode;   // 0 idle, 1 direct, 2 scan
   int m_idx;
   bit m_on;
   int m_cnt;
   bit m_wrap;

   always #5 clk = ~clk;

   decoder_nx_scan #(
      .N        (N),
      .PRESCALE (PRESCALE),
      .OUT_POL  (OUT_POL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .sel       (sel),
      .dout      (dout),
      .idx       (idx),
      .wrap      (wrap),
      .state_dbg (state_dbg)
   );

   function automatic logic [EW-1:0] model_word();
      logic [OUTS-1:0] d;
      dec_state_t      s;
      d = m_on ? (OUTS'(1) << m_idx) : '0;
      if (!OUT_POL) d = ~d;
      s = (m_mode == 2) ? SCAN : (m_mode == 1) ? DIRECT : IDLE;
      return {s, (m_mode == 1), m_wrap, N'(m_idx), d};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_on = 0; m_cnt = 0; m_wrap = 0;
   endtask

   task automatic model_step();
      int nxt;
      nxt = !en ? 0 : (mode && SCAN_ON) ? 2 : 1;
      m_wrap = 0;
      if (m_mode == 1 && sel_valid) begin
         m_idx = sel;
         m_on  = 1;
      end
      if (m_mode == 2 && nxt == 2) begin
         m_cnt++;
         if (m_cnt == PRESCALE) begin
            m_cnt  = 0;
            m_idx  = (m_idx + 1) % OUTS;
            m_wrap = (m_idx == 0);
         end
      end else begin
         m_cnt = 0;
      end
      if (nxt == 2 && m_mode != 2) begin
         m_idx = 0;
         m_on  = 1;
      end
      if (nxt == 0) m_on = 0;
      m_mode = nxt;
   endtask

   task automatic cycle();
      model_step();
      exp_q.push_back(model_word());
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      logic [EW-1:0] want;
      logic [EW-1:0] got;
      rst_n = 1'b0;
      #1;
      model_reset();
      want = model_word();
      got  = {state_dbg, sel_ready, wrap, idx, dout};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL reset_state got=%h want=%h", got, want);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every registered update is compared against the oldest expectation.
   initial begin
      logic [EW-1:0] e;
      logic [EW-1:0] g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state_dbg, sel_ready, wrap, idx, dout};
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL sb_out t=%0t got{st,rdy,wrap,idx,dout}=%h want=%h", $time, g, e);
            end
            total++;
            if (!$onehot0(OUT_POL ? dout : ~dout)) begin
               bad++;
               $display("FAIL multi_hot t=%0t dout=%h want at most one line", $time, dout);
            end
         end
      end
   end

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // DIRECT decode with handshake
      en = 1'b1; mode = 1'b0; sel_valid = 1'b0;
      cycle();
      sel = 3'd5; sel_valid = 1'b1;
      cycle();
      sel = 3'd0;
      cycle();
      sel = 3'd7; sel_valid = 1'b0;
      cycle();
      cycle();
      en = 1'b0;
      cycle();
      cycle();

      // SCAN over more than two periods to see wraps
      en = 1'b1; mode = 1'b1; sel = 3'd2; sel_valid = 1'b1;
      repeat (70) cycle();

      // Reset mid-scan once idx reaches 6, then restart scanning
      for (int i = 0; i < 40 && !(SCAN_ON && m_idx == 6 && m_mode == 2); i++) cycle();
      do_reset();
      repeat (10) cycle();

      // mode=1 with a valid select (DIRECT when SCAN is compiled out)
      do_reset();
      en = 1'b1; mode = 1'b1; sel = 3'd3; sel_valid = 1'b1;
      cycle();
      cycle();
      repeat (5) cycle();

      // Randomised traffic with slowly changing enable/mode
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if ($urandom_range(0, 29) == 0) en = ~en;
         sel_valid = ($urandom_range(0, 2) != 0);
         sel       = N'($urandom_range(0, OUTS - 1));
         cycle();
         if (i == 450) begin
            do_reset();
         end
      end

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain left=%0d want=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
